// File: rtl/median_s_axis_rx.sv
// AXI4-Stream video slave feeding the median filter line buffers.
// Accepts an 8-bit pixel stream framed by tuser (start of frame) and tlast
// (end of line), re-times every accepted in-frame beat onto o_pixel with its
// column/line position, and flags framing errors as single-cycle pulses.
module median_s_axis_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 10,
  parameter int IMG_HEIGHT = 10
) (
  input  logic                  i_clk,
  input  logic                  i_aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tuser,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] o_pixel,
  output logic                  o_image_data_valid,
  output logic                  o_start_of_frame,
  output logic                  o_end_of_frame,
  output logic [11:0]           o_pixel_cnt,
  output logic [11:0]           o_line_cnt,
  output logic                  o_err_early_eol,
  output logic                  o_err_late_eol,
  output logic                  o_err_sof
);

  typedef enum logic [1:0] {
    WAIT_SOF  = 2'd0,
    ACTIVE    = 2'd1,
    FRAME_END = 2'd2
  } state_t;

  localparam logic [11:0] LAST_COL  = 12'(IMG_WIDTH - 1);
  localparam logic [11:0] LAST_LINE = 12'(IMG_HEIGHT - 1);

  state_t                state_q, state_d;
  logic [11:0]           col_q, col_d;
  logic [11:0]           line_q, line_d;
  logic                  tready_q, tready_d;
  logic [DATA_WIDTH-1:0] pixel_q, pixel_d;
  logic                  valid_q, valid_d;
  logic                  sof_q, sof_d;
  logic                  eof_q, eof_d;
  logic [11:0]           pix_cnt_q, pix_cnt_d;
  logic [11:0]           line_cnt_q, line_cnt_d;
  logic                  early_q, early_d;
  logic                  late_q, late_d;
  logic                  err_sof_q, err_sof_d;

  logic                  accept;
  logic                  emit;
  logic                  check_eol;
  logic [11:0]           beat_col;
  logic [11:0]           beat_line;

  assign accept = s_axis_tvalid & tready_q;

  // Framing FSM, position tracking and next values of the re-timed outputs.
  // col_q/line_q hold the position the next accepted beat will occupy.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    line_d     = line_q;
    pixel_d    = pixel_q;
    valid_d    = 1'b0;
    sof_d      = 1'b0;
    eof_d      = 1'b0;
    pix_cnt_d  = pix_cnt_q;
    line_cnt_d = line_cnt_q;
    early_d    = 1'b0;
    late_d     = 1'b0;
    err_sof_d  = 1'b0;
    emit       = 1'b0;
    check_eol  = 1'b0;
    beat_col   = col_q;
    beat_line  = line_q;

    case (state_q)
      WAIT_SOF: begin
        if (accept && s_axis_tuser) begin
          emit      = 1'b1;
          sof_d     = 1'b1;
          beat_col  = 12'd0;
          beat_line = 12'd0;
          check_eol = 1'b1;
          state_d   = ACTIVE;
        end
      end
      ACTIVE: begin
        if (accept) begin
          emit = 1'b1;
          if (s_axis_tuser) begin
            // A restart mid-frame wins over any line-end handling on this beat.
            err_sof_d = 1'b1;
            sof_d     = 1'b1;
            beat_col  = 12'd0;
            beat_line = 12'd0;
            col_d     = 12'd1;
            line_d    = 12'd0;
          end else begin
            check_eol = 1'b1;
          end
        end
      end
      FRAME_END: begin
        state_d = WAIT_SOF;
      end
      default: begin
        state_d = WAIT_SOF;
      end
    endcase

    if (emit) begin
      pixel_d    = s_axis_tdata;
      valid_d    = 1'b1;
      pix_cnt_d  = beat_col;
      line_cnt_d = beat_line;
    end

    if (check_eol) begin
      if (s_axis_tlast || (beat_col == LAST_COL)) begin
        early_d = s_axis_tlast && (beat_col != LAST_COL);
        late_d  = !s_axis_tlast && (beat_col == LAST_COL);
        col_d   = 12'd0;
        if (beat_line == LAST_LINE) begin
          eof_d   = 1'b1;
          line_d  = 12'd0;
          state_d = FRAME_END;
        end else begin
          line_d = beat_line + 12'd1;
        end
      end else begin
        col_d  = beat_col + 12'd1;
        line_d = beat_line;
      end
    end

    tready_d = (state_d != FRAME_END);
  end

  // State, position and output registers; everything clears to zero in reset.
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state_q    <= WAIT_SOF;
      col_q      <= 12'd0;
      line_q     <= 12'd0;
      tready_q   <= 1'b0;
      pixel_q    <= '0;
      valid_q    <= 1'b0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      pix_cnt_q  <= 12'd0;
      line_cnt_q <= 12'd0;
      early_q    <= 1'b0;
      late_q     <= 1'b0;
      err_sof_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      line_q     <= line_d;
      tready_q   <= tready_d;
      pixel_q    <= pixel_d;
      valid_q    <= valid_d;
      sof_q      <= sof_d;
      eof_q      <= eof_d;
      pix_cnt_q  <= pix_cnt_d;
      line_cnt_q <= line_cnt_d;
      early_q    <= early_d;
      late_q     <= late_d;
      err_sof_q  <= err_sof_d;
    end
  end

  assign s_axis_tready      = tready_q;
  assign o_pixel            = pixel_q;
  assign o_image_data_valid = valid_q;
  assign o_start_of_frame   = sof_q;
  assign o_end_of_frame     = eof_q;
  assign o_pixel_cnt        = pix_cnt_q;
  assign o_line_cnt         = line_cnt_q;
  assign o_err_early_eol    = early_q;
  assign o_err_late_eol     = late_q;
  assign o_err_sof          = err_sof_q;

endmodule

// File: tb/tb_median_s_axis_rx.sv
// Scoreboard bench for median_s_axis_rx: directed frames push the expected
// re-timed beats into a queue, and a negedge monitor pops and compares them.
module tb_median_s_axis_rx;

  logic        i_clk;
  logic        i_aresetn;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tuser;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic [7:0]  o_pixel;
  logic        o_image_data_valid;
  logic        o_start_of_frame;
  logic        o_end_of_frame;
  logic [11:0] o_pixel_cnt;
  logic [11:0] o_line_cnt;
  logic        o_err_early_eol;
  logic        o_err_late_eol;
  logic        o_err_sof;

  typedef struct {
    logic [7:0]  data;
    logic [11:0] col;
    logic [11:0] line;
    logic        sof;
    logic        eof;
    logic        early;
    logic        late;
    logic        errSof;
  } exp_t;

  exp_t        expQ[$];
  int          cmpCount = 0;
  int          failCount = 0;
  logic [7:0]  dataByte = 8'h00;
  logic [7:0]  lastPix = 8'h00;
  logic [11:0] lastCol = 12'd0;
  logic [11:0] lastLine = 12'd0;

  median_s_axis_rx #(
    .DATA_WIDTH(8),
    .IMG_WIDTH (10),
    .IMG_HEIGHT(10)
  ) dut (
    .i_clk             (i_clk),
    .i_aresetn         (i_aresetn),
    .s_axis_tdata      (s_axis_tdata),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tuser      (s_axis_tuser),
    .s_axis_tlast      (s_axis_tlast),
    .s_axis_tready     (s_axis_tready),
    .o_pixel           (o_pixel),
    .o_image_data_valid(o_image_data_valid),
    .o_start_of_frame  (o_start_of_frame),
    .o_end_of_frame    (o_end_of_frame),
    .o_pixel_cnt       (o_pixel_cnt),
    .o_line_cnt        (o_line_cnt),
    .o_err_early_eol   (o_err_early_eol),
    .o_err_late_eol    (o_err_late_eol),
    .o_err_sof         (o_err_sof)
  );

  // Free-running 10 ns clock.
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    cmpCount++;
    if (act !== expv) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic checkResetOutputs(input string name);
    checkOutput({name, "_tready"}, 64'(s_axis_tready), 64'd0);
    checkOutput({name, "_valid"}, 64'(o_image_data_valid), 64'd0);
    checkOutput({name, "_pixel"}, 64'(o_pixel), 64'd0);
    checkOutput({name, "_cnts"}, 64'({o_pixel_cnt, o_line_cnt}), 64'd0);
    checkOutput({name, "_flags"}, 64'({o_start_of_frame, o_end_of_frame, o_err_early_eol,
                                      o_err_late_eol, o_err_sof}), 64'd0);
  endtask

  // Drives one beat until accepted; pushes the expected output when emit is set.
  task automatic applyStimulus(input logic user, input logic last, input bit emit,
                               input int col, input int line, input logic sof, input logic eof,
                               input logic early, input logic late, input logic errSof,
                               input bit gap);
    exp_t e;
    bit   acc;
    int   waitCyc;
    if (gap && ($urandom_range(0, 1) == 1)) begin
      @(negedge i_clk);
      s_axis_tvalid = 1'b0;
      @(posedge i_clk);
    end
    dataByte = dataByte + 8'd1;
    e.data   = dataByte;
    e.col    = 12'(col);
    e.line   = 12'(line);
    e.sof    = sof;
    e.eof    = eof;
    e.early  = early;
    e.late   = late;
    e.errSof = errSof;
    if (emit) expQ.push_back(e);
    acc = 1'b0;
    waitCyc = 0;
    while (!acc && waitCyc < 20) begin
      @(negedge i_clk);
      s_axis_tdata  = dataByte;
      s_axis_tvalid = 1'b1;
      s_axis_tuser  = user;
      s_axis_tlast  = last;
      acc = s_axis_tready;
      @(posedge i_clk);
      waitCyc++;
    end
    if (!acc) begin
      cmpCount++;
      failCount++;
      $display("[TB] FAIL accept_timeout: got tready=0 for %0d cycles expected accept", waitCyc);
    end
  endtask

  // Clean 10x10 frame beats idx first..last (idx = line*10 + col).
  task automatic emitRange(input int first, input int last, input bit gap);
    for (int idx = first; idx <= last; idx++) begin
      applyStimulus(idx == 0, (idx % 10) == 9, 1'b1, idx % 10, idx / 10,
                    idx == 0, idx == 99, 1'b0, 1'b0, 1'b0, gap);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge i_clk);
      s_axis_tvalid = 1'b0;
      s_axis_tuser  = 1'b0;
      s_axis_tlast  = 1'b0;
    end
  endtask

  task automatic checkReadyPulse();
    @(negedge i_clk);
    checkOutput("tready_frame_end", 64'(s_axis_tready), 64'd0);
    @(negedge i_clk);
    checkOutput("tready_after_frame_end", 64'(s_axis_tready), 64'd1);
    s_axis_tvalid = 1'b0;
  endtask

  // Monitor: pops the scoreboard on each valid beat; between beats the
  // strobes must be low and pixel/counters must hold the last emitted beat.
  always @(negedge i_clk) begin
    exp_t e;
    if (!i_aresetn) begin
      lastPix  = 8'h00;
      lastCol  = 12'd0;
      lastLine = 12'd0;
    end else if (o_image_data_valid) begin
      cmpCount++;
      if (expQ.size() == 0) begin
        failCount++;
        $display("[TB] FAIL unexpected_beat: got data=%h col=%0d line=%0d expected no beat",
                 o_pixel, o_pixel_cnt, o_line_cnt);
      end else begin
        e = expQ.pop_front();
        if ({o_pixel, o_pixel_cnt, o_line_cnt, o_start_of_frame, o_end_of_frame,
             o_err_early_eol, o_err_late_eol, o_err_sof} !==
            {e.data, e.col, e.line, e.sof, e.eof, e.early, e.late, e.errSof}) begin
          failCount++;
          $display("[TB] FAIL beat: got data=%h col=%0d line=%0d sof/eof/early/late/errsof=%b%b%b%b%b expected data=%h col=%0d line=%0d sof/eof/early/late/errsof=%b%b%b%b%b",
                   o_pixel, o_pixel_cnt, o_line_cnt, o_start_of_frame, o_end_of_frame,
                   o_err_early_eol, o_err_late_eol, o_err_sof,
                   e.data, e.col, e.line, e.sof, e.eof, e.early, e.late, e.errSof);
        end
        lastPix  = e.data;
        lastCol  = e.col;
        lastLine = e.line;
      end
    end else begin
      cmpCount++;
      if ({o_pixel, o_pixel_cnt, o_line_cnt, o_start_of_frame, o_end_of_frame,
           o_err_early_eol, o_err_late_eol, o_err_sof} !==
          {lastPix, lastCol, lastLine, 5'b00000}) begin
        failCount++;
        $display("[TB] FAIL idle_hold: got data=%h col=%0d line=%0d flags=%b%b%b%b%b expected data=%h col=%0d line=%0d flags=00000",
                 o_pixel, o_pixel_cnt, o_line_cnt, o_start_of_frame, o_end_of_frame,
                 o_err_early_eol, o_err_late_eol, o_err_sof, lastPix, lastCol, lastLine);
      end
    end
  end

  // Watchdog so the run always ends on its own.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got no completion expected finish before 300000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    i_aresetn     = 1'b0;
    s_axis_tdata  = 8'h00;
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (3) @(negedge i_clk);
    #2;
    checkResetOutputs("reset_init");
    @(negedge i_clk);
    #2 i_aresetn = 1'b1;
    @(negedge i_clk);
    checkOutput("tready_after_release", 64'(s_axis_tready), 64'd1);

    $display("[TB] test 1: clean frame");
    emitRange(0, 99, 1'b0);
    checkReadyPulse();
    idle(3);

    $display("[TB] test 2: beats before SOF are dropped");
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    emitRange(0, 99, 1'b0);
    idle(3);

    $display("[TB] test 3: early end of line");
    emitRange(0, 25, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 6, 2, 0, 0, 1, 0, 0, 1'b0);
    emitRange(30, 99, 1'b0);
    idle(3);

    $display("[TB] test 4: late end of line");
    emitRange(0, 48, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 9, 4, 0, 0, 0, 1, 0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 0, 5, 0, 0, 1, 0, 0, 1'b0);
    emitRange(60, 99, 1'b0);
    idle(3);

    $display("[TB] test 5: SOF mid-frame");
    emitRange(0, 52, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 0, 0, 1, 0, 0, 0, 1, 1'b0);
    emitRange(1, 99, 1'b0);
    idle(3);

    $display("[TB] test 6: random gaps and reset mid-frame");
    emitRange(0, 44, 1'b1);
    idle(3);
    @(negedge i_clk);
    #2;
    i_aresetn     = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tuser  = 1'b1;
    #1;
    checkResetOutputs("reset_mid");
    @(negedge i_clk);
    checkResetOutputs("reset_mid_hold");
    #2;
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
    i_aresetn     = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 1'b1);
    emitRange(0, 99, 1'b1);
    idle(5);

    checkOutput("scoreboard_empty", 64'(expQ.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
    $finish;
  end

endmodule
